// File: rtl/bus_master_port.sv
// Bus master port: bridges single CPU word requests onto an arbitrated,
// strobed shared bus. Bus access is bounded by a per-access timeout.
module bus_master_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  input  logic        cpu_flush,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic        m_req_,
  input  logic        m_grnt_,
  output logic [29:0] m_addr,
  output logic        m_as_,
  output logic        m_rw,
  output logic [31:0] m_wr_data,
  input  logic [31:0] m_rd_data,
  input  logic        m_rdy_
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_n_q, req_n_d;
  logic        as_n_q, as_n_d;
  logic [29:0] m_addr_q, m_addr_d;
  logic        m_rw_q, m_rw_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    req_n_d   = req_n_q;
    as_n_d    = 1'b1;
    m_addr_d  = m_addr_q;
    m_rw_d    = m_rw_q;
    m_wdata_d = m_wdata_q;
    rd_data_d = rd_data_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req && !cpu_flush) begin
          addr_d  = cpu_addr;
          rw_d    = cpu_rw;
          wdata_d = cpu_wr_data;
          req_n_d = 1'b0;
          state_d = REQ;
        end
      end

      // Flush beats a grant arriving on the same edge.
      REQ: begin
        if (cpu_flush) begin
          req_n_d = 1'b1;
          state_d = IDLE;
        end else if (!m_grnt_) begin
          as_n_d    = 1'b0;
          m_addr_d  = addr_q;
          m_rw_d    = rw_q;
          m_wdata_d = wdata_q;
          cnt_d     = 8'd0;
          state_d   = ACCESS;
        end
      end

      // Ready is checked before the timeout so a last-cycle ready completes cleanly.
      ACCESS: begin
        if (!m_rdy_ || cnt_q == CNT_LAST) begin
          req_n_d   = 1'b1;
          ack_d     = 1'b1;
          m_addr_d  = 30'd0;
          m_rw_d    = 1'b1;
          m_wdata_d = 32'd0;
          state_d   = IDLE;
          if (!m_rdy_) begin
            if (rw_q) rd_data_d = m_rd_data;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        req_n_d   = 1'b1;
        m_addr_d  = 30'd0;
        m_rw_d    = 1'b1;
        m_wdata_d = 32'd0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 30'd0;
      rw_q      <= 1'b0;
      wdata_q   <= 32'd0;
      cnt_q     <= 8'd0;
      req_n_q   <= 1'b1;
      as_n_q    <= 1'b1;
      m_addr_q  <= 30'd0;
      m_rw_q    <= 1'b1;
      m_wdata_q <= 32'd0;
      rd_data_q <= 32'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      req_n_q   <= req_n_d;
      as_n_q    <= as_n_d;
      m_addr_q  <= m_addr_d;
      m_rw_q    <= m_rw_d;
      m_wdata_q <= m_wdata_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign cpu_busy    = (state_q != IDLE);
  assign cpu_rd_data = rd_data_q;
  assign cpu_ack     = ack_q;
  assign cpu_err     = err_q;
  assign m_req_      = req_n_q;
  assign m_as_       = as_n_q;
  assign m_addr      = m_addr_q;
  assign m_rw        = m_rw_q;
  assign m_wr_data   = m_wdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: each transaction's expected
// cycle-by-cycle behaviour is derived from its grant delay and ready latency.
module tb_bus_master_port;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_rw, cpu_flush;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic        cpu_ack, cpu_err, cpu_busy;
  logic        m_req_, m_grnt_, m_as_, m_rw, m_rdy_;
  logic [29:0] m_addr;
  logic [31:0] m_wr_data, m_rd_data;

  logic [67:0] obs;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_rd = 32'd0;

  bus_master_port #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_flush(cpu_flush),
    .cpu_rd_data(cpu_rd_data), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .m_req_(m_req_), .m_grnt_(m_grnt_),
    .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data), .m_rdy_(m_rdy_)
  );

  always #5 clk = ~clk;

  // Observed output bundle: {ack, err, busy, req_, as_, rw, addr, wr_data}
  assign obs = {cpu_ack, cpu_err, cpu_busy, m_req_, m_as_, m_rw, m_addr, m_wr_data};

  function automatic logic [67:0] idle_vec();
    return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 30'd0, 32'd0};
  endfunction

  function automatic logic [67:0] req_vec();
    return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 30'd0, 32'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise();
    cpu_rw      = 1'($urandom);
    cpu_addr    = 30'($urandom);
    cpu_wr_data = $urandom;
    m_rd_data   = $urandom;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cpu_req   = 1'b0;
      cpu_flush = 1'($urandom);
      m_grnt_   = 1'($urandom);
      m_rdy_    = 1'($urandom);
      drive_noise();
      step();
      n_vec++;
      if (obs !== idle_vec()) begin
        n_bad++;
        $display("[TB] FAIL %s idle%0d bus: got %h want %h", tag, i, obs, idle_vec());
      end
      n_vec++;
      if (cpu_rd_data !== exp_rd) begin
        n_bad++;
        $display("[TB] FAIL %s idle%0d rd_data: got %h want %h", tag, i, cpu_rd_data, exp_rd);
      end
    end
  endtask

  // One transaction starting in the current (IDLE) cycle. g = cycles the grant is
  // withheld, r = ACCESS-cycle index where ready arrives (r >= TO means it never does
  // in time). Returns in the ack cycle without advancing the clock.
  task automatic do_transaction(input logic rw, input logic [29:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int g, input int r, input string tag);
    int          a0, len, d;
    logic        tmo, in_acc;
    logic [67:0] exp_v;
    a0  = 2 + g;
    len = (r + 1 < TO) ? r + 1 : TO;
    tmo = (r >= TO);
    d   = a0 + len;

    cpu_req     = 1'b1;
    cpu_flush   = 1'b0;
    cpu_rw      = rw;
    cpu_addr    = addr;
    cpu_wr_data = wd;
    m_grnt_     = 1'($urandom);
    m_rdy_      = 1'($urandom);
    m_rd_data   = $urandom;
    step();

    for (int t = 1; t <= d; t++) begin
      in_acc = (t >= a0) && (t < d);
      exp_v  = {(t == d), (t == d) && tmo, (t < d), !(t < d), (t != a0),
                in_acc ? rw : 1'b1, in_acc ? addr : 30'd0, in_acc ? wd : 32'd0};
      if (t == d && rw && !tmo) exp_rd = rd;
      n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL %s t=%0d bus: got %h want %h", tag, t, obs, exp_v);
      end
      n_vec++;
      if (cpu_rd_data !== exp_rd) begin
        n_bad++;
        $display("[TB] FAIL %s t=%0d rd_data: got %h want %h", tag, t, cpu_rd_data, exp_rd);
      end
      if (t < d) begin
        cpu_req = 1'b0;
        drive_noise();
        if (t < a0) begin
          cpu_flush = 1'b0;
          m_grnt_   = (t == a0 - 1) ? 1'b0 : 1'b1;
          m_rdy_    = 1'($urandom);
        end else begin
          cpu_flush = 1'($urandom);
          m_grnt_   = 1'($urandom);
          m_rdy_    = (t == a0 + r) ? 1'b0 : 1'b1;
          if (t == a0 + r) m_rd_data = rd;
        end
        step();
      end
    end
  endtask

  task automatic test_reset();
    cpu_req = 1'b0; cpu_flush = 1'b0; m_grnt_ = 1'b1; m_rdy_ = 1'b1;
    drive_noise();
    #1 reset = 1'b1;
    #1;
    exp_rd = 32'd0;
    n_vec++;
    if (obs !== idle_vec() || cpu_rd_data !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_async: got %h/%h want %h/0", obs, cpu_rd_data, idle_vec());
    end
    cpu_req = 1'b1;
    step();
    step();
    n_vec++;
    if (obs !== idle_vec() || cpu_rd_data !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_held: got %h/%h want %h/0", obs, cpu_rd_data, idle_vec());
    end
    cpu_req = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic test_read_fast();
    do_transaction(1'b1, 30'h0000100, $urandom, 32'hDEADBEEF, 0, 0, "read_fast");
    idle_cycles(1, "read_fast");
  endtask

  task automatic test_write_delayed();
    do_transaction(1'b0, 30'($urandom), 32'h12345678, $urandom, 4, 2, "write_slow");
    idle_cycles(1, "write_slow");
  endtask

  task automatic test_flush();
    // flush after a cycle of waiting for grant
    cpu_req = 1'b1; cpu_flush = 1'b0; m_grnt_ = 1'b1; m_rdy_ = 1'($urandom);
    drive_noise();
    step();
    for (int t = 1; t <= 2; t++) begin
      n_vec++;
      if (obs !== req_vec()) begin
        n_bad++;
        $display("[TB] FAIL flush_req t=%0d: got %h want %h", t, obs, req_vec());
      end
      cpu_req = 1'b0; m_grnt_ = 1'b1; m_rdy_ = 1'($urandom);
      cpu_flush = (t == 2);
      step();
    end
    n_vec++;
    if (obs !== idle_vec()) begin
      n_bad++;
      $display("[TB] FAIL flush_release: got %h want %h", obs, idle_vec());
    end
    idle_cycles(2, "flush_a");
    // flush and grant on the same edge
    cpu_req = 1'b1; cpu_flush = 1'b0; m_grnt_ = 1'b1;
    drive_noise();
    step();
    n_vec++;
    if (obs !== req_vec()) begin
      n_bad++;
      $display("[TB] FAIL flush_gnt_req: got %h want %h", obs, req_vec());
    end
    cpu_req = 1'b0; cpu_flush = 1'b1; m_grnt_ = 1'b0; m_rdy_ = 1'b0;
    step();
    n_vec++;
    if (obs !== idle_vec()) begin
      n_bad++;
      $display("[TB] FAIL flush_gnt_same_edge: got %h want %h", obs, idle_vec());
    end
    idle_cycles(3, "flush_b");
    // request with flush in IDLE is not accepted
    cpu_req = 1'b1; cpu_flush = 1'b1; m_grnt_ = 1'b0; m_rdy_ = 1'b0;
    step();
    n_vec++;
    if (obs !== idle_vec()) begin
      n_bad++;
      $display("[TB] FAIL flush_in_idle: got %h want %h", obs, idle_vec());
    end
    idle_cycles(1, "flush_c");
  endtask

  task automatic test_timeout();
    do_transaction(1'b1, 30'($urandom), $urandom, $urandom, 0, TO, "tmo_edge");
    idle_cycles(1, "tmo_edge");
    do_transaction(1'b1, 30'($urandom), $urandom, $urandom, 1, TO - 1, "tmo_last_rdy");
    idle_cycles(1, "tmo_last_rdy");
    do_transaction(1'b0, 30'($urandom), $urandom, $urandom, 2, TO + 5, "tmo_never");
    idle_cycles(1, "tmo_never");
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1'b1; cpu_flush = 1'b0; cpu_rw = 1'b1; m_grnt_ = 1'b1; m_rdy_ = 1'b1;
    cpu_addr = 30'($urandom); cpu_wr_data = $urandom;
    step();
    cpu_req = 1'b0; m_grnt_ = 1'b0;
    step();
    m_rdy_ = 1'b1;
    step();
    n_vec++;
    if (m_req_ !== 1'b0 || cpu_busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL midacc_setup: got req_=%b busy=%b want 0/1", m_req_, cpu_busy);
    end
    #2 reset = 1'b1;
    #1;
    exp_rd = 32'd0;
    n_vec++;
    if (obs !== idle_vec() || cpu_rd_data !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL midacc_async: got %h/%h want %h/0", obs, cpu_rd_data, idle_vec());
    end
    m_rdy_ = 1'b0;
    step();
    n_vec++;
    if (obs !== idle_vec()) begin
      n_bad++;
      $display("[TB] FAIL midacc_held: got %h want %h", obs, idle_vec());
    end
    reset = 1'b0;
    do_transaction(1'b1, 30'($urandom), $urandom, $urandom, 0, 1, "after_reset");
    idle_cycles(2, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_transaction(1'($urandom), 30'($urandom), $urandom, $urandom,
                     $urandom_range(0, 2), $urandom_range(0, 2), "b2b");
    idle_cycles(1, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_transaction(1'($urandom), 30'($urandom), $urandom, $urandom,
                     $urandom_range(0, 4), $urandom_range(0, TO + 2), "rand");
      idle_cycles($urandom_range(0, 2), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_read_fast();
    test_write_delayed();
    test_flush();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
